alu_mdu_mips: RTL and testbench

Parametrised MIPS execute-stage ALU with an attached multi-cycle multiply/divide unit and HI/LO registers. Single-cycle logic, shift, add/subtract and compare operations are combinational. Unsigned multiply and divide run iteratively, one bit per clock, under a start/busy/done handshake. The block sits in the datapath's execute stage; the controller holds the pipeline while `Busy` is high.

---
 rtl/alu_mdu_mips.sv | 155 +++++++++++++++
 tb/tb_alu_mdu_mips.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_mips.sv
// MIPS execute-stage ALU with an iterative unsigned multiply/divide unit.
// MULTU/DIVU take one bit per clock; their results land in HI/LO.
module alu_mdu_mips #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] SrcA,
    input  logic [DATA_SIZE-1:0] SrcB,
    input  logic [3:0]           ALUControl,
    input  logic                 Start,
    output logic [DATA_SIZE-1:0] ALUResult,
    output logic                 Zero,
    output logic                 Overflow,
    output logic                 Busy,
    output logic                 Done,
    output logic                 DivZero
);
    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_SIZE - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_MULTU = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_DIVU  = 4'b1000;
    localparam logic [3:0] OP_MFHI  = 4'b1001;
    localparam logic [3:0] OP_MFLO  = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1011;
    localparam logic [3:0] OP_SLL   = 4'b1100;
    localparam logic [3:0] OP_SRL   = 4'b1101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_e;

    state_e                   state, state_nx;
    logic [CNT_W-1:0]         cnt;
    logic [DATA_SIZE-1:0]     hi, lo, opnd;
    logic [2*DATA_SIZE-1:0]   acc, acc_nx;
    logic [DATA_SIZE:0]       mul_sum, div_sh, div_diff;
    logic                     accept, is_mul, is_div, div_by0, last_step;
    logic [DATA_SIZE-1:0]     sum, diff;

    assign accept    = Start && (state == IDLE || state == FIN);
    assign is_mul    = accept && ALUControl == OP_MULTU;
    assign is_div    = accept && ALUControl == OP_DIVU && SrcB != '0;
    assign div_by0   = accept && ALUControl == OP_DIVU && SrcB == '0;
    assign last_step = (state == MUL || state == DIV) && cnt == LAST;

    // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    assign mul_sum  = {1'b0, acc[2*DATA_SIZE-1:DATA_SIZE]} + {1'b0, opnd & {DATA_SIZE{acc[0]}}};
    assign div_sh   = {acc[2*DATA_SIZE-1:DATA_SIZE], acc[DATA_SIZE-1]};
    assign div_diff = div_sh - {1'b0, opnd};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        acc_nx   = acc;
        state_nx = state;
        case (state)
            MUL: acc_nx = {mul_sum, acc[DATA_SIZE-1:1]};
            DIV: begin
                if (!div_diff[DATA_SIZE])
                    acc_nx = {div_diff[DATA_SIZE-1:0], acc[DATA_SIZE-2:0], 1'b1};
                else
                    acc_nx = {div_sh[DATA_SIZE-1:0], acc[DATA_SIZE-2:0], 1'b0};
            end
            default: ;
        endcase
        case (state)
            IDLE, FIN: begin
                state_nx = IDLE;
                if (is_mul)       state_nx = MUL;
                else if (is_div)  state_nx = DIV;
                else if (div_by0) state_nx = FIN;
            end
            default: if (cnt == LAST) state_nx = FIN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            hi      <= '0;
            lo      <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nx;
            Busy  <= (state_nx == MUL || state_nx == DIV);
            Done  <= (state_nx == FIN);
            if (is_mul) begin
                acc  <= {{DATA_SIZE{1'b0}}, SrcB};
                opnd <= SrcA;
                cnt  <= '0;
            end else if (is_div) begin
                acc  <= {{DATA_SIZE{1'b0}}, SrcA};
                opnd <= SrcB;
                cnt  <= '0;
            end else if (state == MUL || state == DIV) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end
            if (div_by0) begin
                hi <= SrcA;
                lo <= '1;
            end else if (last_step) begin
                {hi, lo} <= acc_nx;
            end
            if (is_mul || is_div || div_by0)
                DivZero <= div_by0;
        end
    end

    assign sum  = SrcA + SrcB;
    assign diff = SrcA - SrcB;

    always_comb begin
        ALUResult = '0;
        Overflow  = 1'b0;
        case (ALUControl)
            OP_AND:  ALUResult = SrcA & SrcB;
            OP_OR:   ALUResult = SrcA | SrcB;
            OP_ADD: begin
                ALUResult = sum;
                Overflow  = (SrcA[DATA_SIZE-1] == SrcB[DATA_SIZE-1]) &&
                            (sum[DATA_SIZE-1] != SrcA[DATA_SIZE-1]);
            end
            OP_XOR:  ALUResult = SrcA ^ SrcB;
            OP_SUB: begin
                ALUResult = diff;
                Overflow  = (SrcA[DATA_SIZE-1] != SrcB[DATA_SIZE-1]) &&
                            (diff[DATA_SIZE-1] != SrcA[DATA_SIZE-1]);
            end
            OP_SLT:  ALUResult = DATA_SIZE'($signed(SrcA) < $signed(SrcB));
            OP_SLTU: ALUResult = DATA_SIZE'(SrcA < SrcB);
            OP_MFHI: ALUResult = hi;
            OP_MFLO: ALUResult = lo;
            OP_NOR:  ALUResult = ~(SrcA | SrcB);
            OP_SLL:  ALUResult = SrcA << SrcB[CNT_W-2:0];
            OP_SRL:  ALUResult = SrcA >> SrcB[CNT_W-2:0];
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_alu_mdu_mips.sv
// Randomised self-checking bench for alu_mdu_mips against a plain-arithmetic
// reference model (32-bit instance plus an 8-bit instance).
module tb_alu_mdu_mips;
    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] SrcA, SrcB, ALUResult;
    logic [3:0]  ALUControl;
    logic        Start, Zero, Overflow, Busy, Done, DivZero;

    logic [7:0]  a8, b8, res8;
    logic [3:0]  op8;
    logic        start8, zero8, ov8, busy8, done8, dz8;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    always #5 clk = ~clk;

    alu_mdu_mips #(.DATA_SIZE(32)) dut (
        .clk(clk), .rst(rst), .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .Start(Start), .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow),
        .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    alu_mdu_mips #(.DATA_SIZE(8)) dut8 (
        .clk(clk), .rst(rst), .SrcA(a8), .SrcB(b8), .ALUControl(op8),
        .Start(start8), .ALUResult(res8), .Zero(zero8), .Overflow(ov8),
        .Busy(busy8), .Done(done8), .DivZero(dz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU: {overflow, result}, built from integer arithmetic.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint s;
        logic [31:0] r = '0;
        logic        ov = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin r = a + b; s = sa + sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3:  r = a ^ b;
            4'd4:  begin r = a - b; s = sa - sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd6:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd9:  r = m_hi;
            4'd10: r = m_lo;
            4'd11: r = ~(a | b);
            4'd12: r = a << (b % 32);
            4'd13: r = a >> (b % 32);
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    task automatic alu_chk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [32:0] e;
        ALUControl = op; SrcA = a; SrcB = b; Start = 1'b0;
        #1;
        e = ref_alu(op, a, b);
        check({tag, ".res"}, ALUResult, e[31:0]);
        check({tag, ".zero"}, Zero, e[31:0] == 0);
        check({tag, ".ovf"}, Overflow, e[32]);
    endtask

    task automatic read_hilo(input string tag);
        ALUControl = 4'd9;  #1 check({tag, ".hi"}, ALUResult, m_hi);
        ALUControl = 4'd10; #1 check({tag, ".lo"}, ALUResult, m_lo);
    endtask

    // Launch MULTU/DIVU and follow it cycle by cycle through to Done.
    task automatic md_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit stray);
        logic [63:0] p;
        logic [31:0] e_hi, e_lo;
        bit          dz0;
        dz0 = (op == 4'd8) && (b == 0);
        if (op == 4'd5) begin
            p = {32'b0, a} * {32'b0, b};
            e_hi = p[63:32]; e_lo = p[31:0];
        end else if (dz0) begin
            e_hi = a; e_lo = '1;
        end else begin
            e_hi = a % b; e_lo = a / b;
        end
        @(negedge clk);
        SrcA = a; SrcB = b; ALUControl = op; Start = 1'b1;
        #1 check("md.res0", ALUResult, 0);
        @(posedge clk); #1;
        Start = 1'b0;
        m_dz  = dz0;
        if (dz0) begin
            check("dz.done", Done, 1);
            check("dz.busy", Busy, 0);
            check("dz.flag", DivZero, 1);
            m_hi = e_hi; m_lo = e_lo;
            read_hilo("dz");
        end else begin
            ALUControl = 4'd9; SrcA = $urandom; SrcB = $urandom;
            for (int i = 1; i <= N; i++) begin
                check("md.busy", Busy, 1);
                check("md.done_early", Done, 0);
                if (i == 1) begin
                    check("md.dz_clear", DivZero, 0);
                    #1 check("md.old_hi", ALUResult, m_hi);
                end
                if (stray && i == 5) begin ALUControl = 4'd8; SrcB = 32'd3; Start = 1'b1; end
                if (i == 6) begin ALUControl = 4'd9; Start = 1'b0; end
                @(posedge clk); #1;
            end
            check("md.done", Done, 1);
            check("md.busy_end", Busy, 0);
            check("md.dz", DivZero, 0);
            m_hi = e_hi; m_lo = e_lo;
            read_hilo("md");
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7fffffff;
            3: return 32'h80000000;
            4: return 32'hffffffff;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        logic [15:0] p8;
        rst = 1'b1; SrcA = '0; SrcB = '0; ALUControl = '0; Start = 1'b0;
        a8 = '0; b8 = '0; op8 = '0; start8 = 1'b0;
        #2;
        check("rst.busy", Busy, 0);
        check("rst.done", Done, 0);
        check("rst.dz", DivZero, 0);
        read_hilo("rst");
        alu_chk(4'd2, 32'd3, 32'd4, "rst.add");
        @(negedge clk); rst = 1'b0;

        // Directed boundary cases.
        alu_chk(4'd2, 32'h7fffffff, 32'h1, "add_ovf");
        check("add_ovf.const", {Overflow, ALUResult}, {1'b1, 32'h80000000});
        alu_chk(4'd4, 32'd5, 32'd5, "sub_zero");
        check("sub_zero.const", Zero, 1);
        alu_chk(4'd6, 32'h80000000, 32'd1, "slt");
        check("slt.const", ALUResult, 1);
        alu_chk(4'd7, 32'h80000000, 32'd1, "sltu");
        check("sltu.const", ALUResult, 0);
        alu_chk(4'd4, 32'h80000000, 32'd1, "sub_ovf");
        alu_chk(4'd6, 32'h7fffffff, 32'hffffffff, "slt_ovf");
        alu_chk(4'd14, 32'hdead, 32'hbeef, "op14");
        alu_chk(4'd15, 32'hdead, 32'hbeef, "op15");

        md_op(4'd5, 32'hffffffff, 32'hffffffff, 1'b0);
        check("mul.hi_const", m_hi, 32'hfffffffe);
        md_op(4'd8, 32'd100, 32'd7, 1'b1);
        check("div.q_const", {m_hi, m_lo}, {32'd2, 32'd14});
        md_op(4'd8, 32'd9, 32'd0, 1'b0);
        md_op(4'd5, 32'h12345678, 32'h9abcdef0, 1'b0);
        md_op(4'd8, 32'hffffffff, 32'd1, 1'b0);
        md_op(4'd8, 32'd5, 32'hffffffff, 1'b0);

        // Reset in the middle of a MULTU.
        @(negedge clk);
        SrcA = 32'hffffffff; SrcB = 32'h3; ALUControl = 4'd5; Start = 1'b1;
        @(posedge clk); #1 Start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort.busy", Busy, 0);
        check("abort.done", Done, 0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        read_hilo("abort");
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < N + 5; i++) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        check("abort.no_done", dones, 0);
        check("abort.idle", Busy, 0);

        // Randomised combinational ops.
        for (int i = 0; i < 300; i++)
            alu_chk(4'($urandom_range(0, 15)), pick(), pick(), "rnd_alu");

        // Randomised multiply/divide, including back-to-back issue in FIN.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = pick(); b = ($urandom_range(0, 4) == 0) ? 32'd0 : pick();
            md_op($urandom_range(0, 1) ? 4'd5 : 4'd8, a, b, 1'($urandom_range(0, 1)));
            if (i % 4 == 0) alu_chk(4'($urandom_range(9, 10)), pick(), pick(), "rnd_mfhilo");
        end

        // 8-bit build.
        for (int t = 0; t < 4; t++) begin
            logic [7:0] x, y, e_hi, e_lo;
            bit         mul;
            mul = (t == 0) || (t == 2);
            x = (t == 0) ? 8'hff : 8'($urandom);
            y = (t == 0) ? 8'hff : 8'($urandom_range(1, 255));
            if (mul) begin
                p8 = {8'b0, x} * {8'b0, y};
                e_hi = p8[15:8]; e_lo = p8[7:0];
            end else begin
                e_hi = x % y; e_lo = x / y;
            end
            @(negedge clk);
            a8 = x; b8 = y; op8 = mul ? 4'd5 : 4'd8; start8 = 1'b1;
            @(posedge clk); #1 start8 = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                check("w8.busy", busy8, 1);
                check("w8.done_early", done8, 0);
                @(posedge clk); #1;
            end
            check("w8.done", done8, 1);
            op8 = 4'd9;  #1 check("w8.hi", res8, e_hi);
            op8 = 4'd10; #1 check("w8.lo", res8, e_lo);
            if (t == 0) check("w8.const", {e_hi, e_lo}, 16'hfe01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
